// File: rtl/regn_arb_pkg.sv
// regn_arb shared definitions: default sizes, state encoding and the
// rotating-priority pick function used by rr_prio.
package regn_arb_pkg;

    localparam int W_DEF  = 32;
    localparam int N_DEF  = 4;
    localparam int CNT_W  = 16;
    localparam int N_MAX  = 16;
    localparam int SW_MAX = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic              any;
        logic [SW_MAX-1:0] idx;
    } pick_t;

    // First valid requester searching ptr, ptr+1, ... wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [N_MAX-1:0]  valid,
        input logic [SW_MAX-1:0] ptr,
        input int                n
    );
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < N_MAX; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !r.any && valid[j[SW_MAX-1:0]]) begin
                r.any = 1'b1;
                r.idx = j[SW_MAX-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regn_arb_rr_prio.sv
// rr_prio: combinational rotating-priority picker.
// Produces a one-hot grant, the winner index and an any-valid flag.
module rr_prio
    import regn_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [SW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [SW-1:0] idx_o,
    output logic          any_o
);

    logic [N_MAX-1:0] v;
    pick_t            pk;

    // Widen to the package maximum, pick, then narrow back.
    always_comb begin
        v          = '0;
        v[N-1:0]   = valid_i;
        pk         = rr_pick(v, SW_MAX'(ptr_i), N);
        any_o      = pk.any;
        idx_o      = pk.idx[SW-1:0];
        gnt_o      = '0;
        if (pk.any) begin
            gnt_o[pk.idx[SW-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/regn_arb.sv
// regn_arb: N-way round-robin arbiter feeding one shared output register.
// Optional REGN_ARB_CNT_EN adds a saturating accepted-transfer counter.
module regn_arb
    import regn_arb_pkg::*;
#(
    parameter  int W  = W_DEF,
    parameter  int N  = N_DEF,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid_i,
    input  logic [N*W-1:0] req_data_i,
    output logic [N-1:0]   req_ready_o,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic [SW-1:0]  out_src_o,
    input  logic           out_ready_i
`ifdef REGN_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt_o
`endif
);

    state_t        state_q, state_d;
    logic [W-1:0]  data_q,  data_d;
    logic [SW-1:0] src_q,   src_d;
    logic [SW-1:0] ptr_q,   ptr_d;

    logic [N-1:0]  gnt;
    logic [SW-1:0] idx;
    logic          any;
    logic          load;
    logic          xfer;
    logic [W-1:0]  pick_data;

    rr_prio #(
        .N  (N),
        .SW (SW)
    ) u_prio (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (idx),
        .any_o   (any)
    );

    assign load        = (state_q == EMPTY) | out_ready_i;
    assign xfer        = load & any;
    assign req_ready_o = load ? gnt : '0;
    assign out_valid_o = (state_q == FULL);
    assign out_data_o  = data_q;
    assign out_src_o   = src_q;

    // Select the winning requester's word.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SW'(i)) begin
                pick_data = req_data_i[i*W +: W];
            end
        end
    end

    // Next state: load a winner, drain when idle, hold under backpressure.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (any) begin
                state_d = FULL;
                data_d  = pick_data;
                src_d   = idx;
                ptr_d   = (int'(idx) == N - 1) ? '0 : idx + SW'(1);
            end else begin
                state_d = EMPTY;
            end
        end
    end

    // Register stage and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef REGN_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d      = (xfer && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    assign xfer_cnt_o = cnt_q;

    // Saturating count of accepted transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_regn_arb.sv
// tb_regn_arb: directed self-checking bench for regn_arb (N=4, W=32).
// Define REGN_ARB_CNT_EN to also exercise the transfer counter.
module tb_regn_arb;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [31:0]  d [4];
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_ready;
`ifdef REGN_ARB_CNT_EN
    logic [15:0]  xfer_cnt;
`endif

    int n_chk;
    int n_fail;
    int proto_fail;

    logic [3:0]  pend;
    logic [31:0] pdata [4];

    assign req_data = {d[3], d[2], d[1], d[0]};

    regn_arb #(.W(32), .N(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_ready_i (out_ready)
`ifdef REGN_ARB_CNT_EN
        ,
        .xfer_cnt_o  (xfer_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester rule: a pending request keeps valid and data until accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && (!req_valid[i] || d[i] !== pdata[i])) begin
                    proto_fail++;
                    $display("FAIL proto req%0d: valid %b data %h, held data %h",
                             i, req_valid[i], d[i], pdata[i]);
                end
            end
            pend = req_valid & ~req_ready;
            for (int i = 0; i < 4; i++) pdata[i] = d[i];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 32'hA000_0000 | i;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 32'hA000_0000 | i;
        repeat (2) tick();
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b d=%h s=%0d, want 0 0 0",
                     out_valid, out_data, out_src);
        end
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        #1;
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_empty_ready: %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'hA000_0000) begin
            n_fail++;
            $display("FAIL reset_load: v=%b d=%h want 1 a0000000",
                     out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_async: v=%b d=%h s=%0d, want 0 0 0",
                     out_valid, out_data, out_src);
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: %b want 0001", req_ready);
        end
        tick();
        n_chk++;
        if (out_src !== 2'd0 || out_data !== 32'hA000_0000) begin
            n_fail++;
            $display("FAIL reset_first_word: s=%0d d=%h want 0 a0000000",
                     out_src, out_data);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_src [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [3:0] exp_gnt [8] = '{4'h1, 4'h2, 4'h4, 4'h8,
                                    4'h1, 4'h2, 4'h4, 4'h8};
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_chk++;
            if (req_ready !== exp_gnt[k]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: %b want %b", k, req_ready, exp_gnt[k]);
            end
            tick();
            n_chk++;
            if (out_valid !== 1'b1 || out_src !== exp_src[k] ||
                out_data !== (32'hA000_0000 | 32'(exp_src[k]))) begin
                n_fail++;
                $display("FAIL rr_word[%0d]: v=%b s=%0d d=%h want 1 %0d",
                         k, out_valid, out_src, out_data, exp_src[k]);
            end
        end
    endtask

    task automatic test_skip_wrap;
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0110;
        #1;
        n_chk++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL skip_grant1: %b want 0010", req_ready);
        end
        tick();
        n_chk++;
        if (out_src !== 2'd1 || out_data !== 32'hA000_0001) begin
            n_fail++;
            $display("FAIL skip_word1: s=%0d d=%h want 1 a0000001", out_src, out_data);
        end
        req_valid = 4'b0100;
        #1;
        n_chk++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL skip_grant2: %b want 0100", req_ready);
        end
        tick();
        n_chk++;
        if (out_src !== 2'd2) begin
            n_fail++;
            $display("FAIL skip_word2: s=%0d want 2", out_src);
        end
        req_valid = 4'b1001;
        #1;
        n_chk++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_grant3: %b want 1000", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        #1;
        n_chk++;
        if (out_src !== 2'd3 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_to0: s=%0d rdy=%b want 3 0001", out_src, req_ready);
        end
        tick();
        n_chk++;
        if (out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_word0: s=%0d want 0", out_src);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        d[0]      = 32'hDEAD_BEEF;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_chk++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: %b want 0000", k, req_ready);
            end
            tick();
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: v=%b d=%h s=%0d want 1 deadbeef 0",
                         k, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release: %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b0100;
        n_chk++;
        if (out_src !== 2'd1 || out_data !== 32'hA000_0001) begin
            n_fail++;
            $display("FAIL bp_next: s=%0d d=%h want 1 a0000001", out_src, out_data);
        end
        tick();
        req_valid = 4'b0000;
        n_chk++;
        if (out_src !== 2'd2 || out_data !== 32'hA000_0002) begin
            n_fail++;
            $display("FAIL bp_next2: s=%0d d=%h want 2 a0000002", out_src, out_data);
        end
    endtask

    task automatic test_drain;
        do_reset();
        out_ready = 1'b1;
        d[2]      = 32'h0000_00A5;
        req_valid = 4'b0100;
        #1;
        n_chk++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL drain_grant: %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        n_chk++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 ||
            out_data !== 32'h0000_00A5 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL drain_full: v=%b s=%0d d=%h rdy=%b want 1 2 a5 0000",
                     out_valid, out_src, out_data, req_ready);
        end
        repeat (2) begin
            tick();
            n_chk++;
            if (out_valid !== 1'b0 || out_data !== 32'h0000_00A5 || out_src !== 2'd2) begin
                n_fail++;
                $display("FAIL drain_empty: v=%b d=%h s=%0d want 0 a5 2",
                         out_valid, out_data, out_src);
            end
        end
    endtask

`ifdef REGN_ARB_CNT_EN
    task automatic test_counter;
        do_reset();
        #1;
        n_chk++;
        if (xfer_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_reset: %h want 0000", xfer_cnt);
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        repeat (3) tick();
        n_chk++;
        if (xfer_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL cnt_3: %h want 0003", xfer_cnt);
        end
        repeat (65532) tick();
        n_chk++;
        if (xfer_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_65535: %h want ffff", xfer_cnt);
        end
        repeat (70000 - 65535) tick();
        n_chk++;
        if (xfer_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_sat: %h want ffff", xfer_cnt);
        end
    endtask
`endif

    task automatic test_protocol;
        n_chk++;
        if (proto_fail !== 0) begin
            n_fail++;
            $display("FAIL protocol: %0d violations want 0", proto_fail);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        proto_fail = 0;
        pend       = '0;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_drain();
`ifdef REGN_ARB_CNT_EN
        test_counter();
`endif
        do_reset();
        tick();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
